// File: rtl/calib_sequencer.sv
// Colour-calibration controller: arms the calibration unit on a frame boundary, accumulates
// NUM_FRAMES frames, then stores Y and saturated U/V threshold windows into a colour slot.
module calib_sequencer #(
  parameter int NUM_SLOTS  = 4,
  parameter int SLOT_W     = 2,
  parameter int NUM_FRAMES = 2,
  parameter int TOL        = 16,
  parameter int TO_W       = 24
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cal_req,
  input  logic [SLOT_W-1:0]    cal_slot,
  input  logic                 cal_abort,
  input  logic                 clear_all,
  input  logic                 frame_start,
  input  logic [7:0]           Y_in,
  input  logic signed [8:0]    U_in,
  input  logic signed [8:0]    V_in,
  output logic                 cal_start,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [NUM_SLOTS-1:0] slot_valid,
  input  logic [SLOT_W-1:0]    rd_slot,
  output logic [7:0]           rd_Y,
  output logic signed [8:0]    rd_U_min,
  output logic signed [8:0]    rd_U_max,
  output logic signed [8:0]    rd_V_min,
  output logic signed [8:0]    rd_V_max,
  output logic [2:0]           state_dbg
);

  localparam int FC_W = $clog2(NUM_FRAMES + 1);
  localparam logic signed [9:0] TOL10 = 10'(TOL);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_ACCUM = 3'd2,
    S_LATCH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [SLOT_W-1:0] slot_q;
  logic [FC_W-1:0]   frame_cnt_q;
  logic [TO_W-1:0]   wd_q;
  logic              cal_start_q;
  logic              timeout_q;

  logic cal_slot_ok;
  logic accept, clear, arm_go, frame_inc, expire, wr_en, wd_run, wd_last;

  logic [7:0]        y_q    [NUM_SLOTS];
  logic signed [8:0] umin_q [NUM_SLOTS];
  logic signed [8:0] umax_q [NUM_SLOTS];
  logic signed [8:0] vmin_q [NUM_SLOTS];
  logic signed [8:0] vmax_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] valid_q;

  logic signed [9:0] u_ext, v_ext;

  function automatic logic signed [8:0] sat9(input logic signed [9:0] x);
    if (x > 10'sd255)
      return 9'sh0FF;
    else if (x < -10'sd256)
      return 9'sh100;
    else
      return x[8:0];
  endfunction

  always_comb begin
    cal_slot_ok = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++)
      if (cal_slot == SLOT_W'(i)) cal_slot_ok = 1'b1;
  end

  // The watchdog expires on the increment that would bring it to all ones.
  assign wd_last = (wd_q == {{(TO_W-1){1'b1}}, 1'b0});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  // cal_req is a fire-and-forget pulse: accepted only in IDLE with a legal slot,
  // never queued; clear_all likewise acts only in IDLE and loses to a same-cycle cal_req.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    clear     = 1'b0;
    arm_go    = 1'b0;
    frame_inc = 1'b0;
    expire    = 1'b0;
    wr_en     = 1'b0;
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    case (state_q)
      S_IDLE: begin
        if (cal_req && cal_slot_ok) begin
          accept  = 1'b1;
          state_d = S_ARM;
        end else if (clear_all) begin
          clear = 1'b1;
        end
      end
      S_ARM: begin
        if (cal_abort) begin
          state_d = S_IDLE;
        end else if (frame_start) begin
          arm_go  = 1'b1;
          state_d = S_ACCUM;
        end else if (wd_last) begin
          expire  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ACCUM: begin
        if (cal_abort) begin
          state_d = S_IDLE;
        end else if (frame_start) begin
          frame_inc = 1'b1;
          if (frame_cnt_q == FC_W'(NUM_FRAMES - 1)) state_d = S_LATCH;
        end else if (wd_last) begin
          expire  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_LATCH: begin
        if (cal_abort) begin
          state_d = S_IDLE;
        end else begin
          wr_en   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign wd_run = ((state_q == S_ARM) || (state_q == S_ACCUM)) &&
                  ((state_d == S_ARM) || (state_d == S_ACCUM));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_q      <= '0;
      frame_cnt_q <= '0;
      wd_q        <= '0;
      cal_start_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      cal_start_q <= arm_go;
      timeout_q   <= expire;
      if (accept) slot_q <= cal_slot;
      if (arm_go)
        frame_cnt_q <= '0;
      else if (frame_inc)
        frame_cnt_q <= frame_cnt_q + FC_W'(1);
      if (wd_run)
        wd_q <= frame_start ? '0 : wd_q + TO_W'(1);
      else
        wd_q <= '0;
    end
  end

  assign u_ext = {U_in[8], U_in};
  assign v_ext = {V_in[8], V_in};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        y_q[i]    <= '0;
        umin_q[i] <= '0;
        umax_q[i] <= '0;
        vmin_q[i] <= '0;
        vmax_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (wr_en && (slot_q == SLOT_W'(i))) begin
          y_q[i]    <= Y_in;
          umin_q[i] <= sat9(u_ext - TOL10);
          umax_q[i] <= sat9(u_ext + TOL10);
          vmin_q[i] <= sat9(v_ext - TOL10);
          vmax_q[i] <= sat9(v_ext + TOL10);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else if (clear) begin
      valid_q <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_SLOTS; i++)
        if (slot_q == SLOT_W'(i)) valid_q[i] <= 1'b1;
    end
  end

  // Out-of-range read selects fall through to the zero defaults.
  always_comb begin
    rd_Y     = '0;
    rd_U_min = '0;
    rd_U_max = '0;
    rd_V_min = '0;
    rd_V_max = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (rd_slot == SLOT_W'(i)) begin
        rd_Y     = y_q[i];
        rd_U_min = umin_q[i];
        rd_U_max = umax_q[i];
        rd_V_min = vmin_q[i];
        rd_V_max = vmax_q[i];
      end
    end
  end

  assign cal_start  = cal_start_q;
  assign timeout    = timeout_q;
  assign slot_valid = valid_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_calib_sequencer.sv
// Directed-plus-random bench for calib_sequencer; expected slot contents come from a
// clamp-arithmetic model of the calibration rules.
module tb_calib_sequencer;

  localparam int NUM_SLOTS  = 4;
  localparam int SLOT_W     = 2;
  localparam int NUM_FRAMES = 2;
  localparam int TOL        = 16;
  localparam int TO_W       = 6;
  localparam int WD_LIMIT   = (1 << TO_W) - 1;

  logic                 clk;
  logic                 reset_n;
  logic                 cal_req;
  logic [SLOT_W-1:0]    cal_slot;
  logic                 cal_abort;
  logic                 clear_all;
  logic                 frame_start;
  logic [7:0]           Y_in;
  logic signed [8:0]    U_in;
  logic signed [8:0]    V_in;
  logic                 cal_start;
  logic                 busy;
  logic                 done;
  logic                 timeout;
  logic [NUM_SLOTS-1:0] slot_valid;
  logic [SLOT_W-1:0]    rd_slot;
  logic [7:0]           rd_Y;
  logic signed [8:0]    rd_U_min, rd_U_max, rd_V_min, rd_V_max;
  logic [2:0]           state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0, cs_cnt = 0, dn_cnt = 0, to_cnt = 0, cs_cyc = 0, to_cyc = 0;
  int last_fs_cyc = 0, req_cyc = 0;

  int exp_y    [NUM_SLOTS];
  int exp_umin [NUM_SLOTS];
  int exp_umax [NUM_SLOTS];
  int exp_vmin [NUM_SLOTS];
  int exp_vmax [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] exp_valid;
  logic [SLOT_W-1:0]    exp_q[$];

  calib_sequencer #(
    .NUM_SLOTS(NUM_SLOTS), .SLOT_W(SLOT_W), .NUM_FRAMES(NUM_FRAMES), .TOL(TOL), .TO_W(TO_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cal_req(cal_req), .cal_slot(cal_slot),
    .cal_abort(cal_abort), .clear_all(clear_all), .frame_start(frame_start),
    .Y_in(Y_in), .U_in(U_in), .V_in(V_in), .cal_start(cal_start), .busy(busy),
    .done(done), .timeout(timeout), .slot_valid(slot_valid), .rd_slot(rd_slot),
    .rd_Y(rd_Y), .rd_U_min(rd_U_min), .rd_U_max(rd_U_max), .rd_V_min(rd_V_min),
    .rd_V_max(rd_V_max), .state_dbg(state_dbg)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (cal_start) begin cs_cnt++; cs_cyc = cyc; end
    if (done) dn_cnt++;
    if (timeout) begin to_cnt++; to_cyc = cyc; end
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input int x);
    if (x > 255) return 255;
    if (x < -256) return -256;
    return x;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_SLOTS; i++) begin
      exp_y[i] = 0; exp_umin[i] = 0; exp_umax[i] = 0; exp_vmin[i] = 0; exp_vmax[i] = 0;
    end
    exp_valid = '0;
  endtask

  task automatic model_write(input int slot, input int y, input int u, input int v);
    exp_y[slot]    = y;
    exp_umin[slot] = clamp(u - TOL);
    exp_umax[slot] = clamp(u + TOL);
    exp_vmin[slot] = clamp(v - TOL);
    exp_vmax[slot] = clamp(v + TOL);
    exp_valid[slot] = 1'b1;
  endtask

  task automatic check_slots();
    for (int i = 0; i < NUM_SLOTS; i++) begin
      rd_slot = SLOT_W'(i);
      #1;
      check($sformatf("rd_y[%0d]", i), rd_Y, exp_y[i]);
      check($sformatf("rd_umin[%0d]", i), rd_U_min, exp_umin[i]);
      check($sformatf("rd_umax[%0d]", i), rd_U_max, exp_umax[i]);
      check($sformatf("rd_vmin[%0d]", i), rd_V_min, exp_vmin[i]);
      check($sformatf("rd_vmax[%0d]", i), rd_V_max, exp_vmax[i]);
    end
  endtask

  // Driver tasks
  task automatic request(input int slot, input bit clr);
    cal_req = 1'b1; cal_slot = SLOT_W'(slot); clear_all = clr; req_cyc = cyc;
    @(posedge clk); #1;
    cal_req = 1'b0; clear_all = 1'b0;
  endtask

  task automatic frame_pulse(input int gap);
    repeat (gap) @(posedge clk);
    #1; frame_start = 1'b1; last_fs_cyc = cyc;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic run_cal(input int slot, input int y, input int u, input int v, input bit with_clear);
    int cs0, dn0, to0, first_fs, waited;
    logic [SLOT_W-1:0] s;
    Y_in = 8'(y); U_in = 9'(u); V_in = 9'(v);
    cs0 = cs_cnt; dn0 = dn_cnt; to0 = to_cnt; first_fs = 0;
    request(slot, with_clear);
    exp_q.push_back(SLOT_W'(slot));
    // Frame gaps stay below the watchdog limit
    for (int f = 0; f <= NUM_FRAMES; f++) begin
      frame_pulse($urandom_range(3, 50));
      if (f == 0) first_fs = last_fs_cyc;
      @(negedge clk);
      check("busy_during_cal", busy, 1);
      check("valid_hold", slot_valid, exp_valid);
    end
    waited = 0;
    while (dn_cnt == dn0 && waited < 10) begin @(posedge clk); waited++; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    model_write(slot, y, u, v);
    check("done_pulses", dn_cnt - dn0, 1);
    check("cal_start_pulses", cs_cnt - cs0, 1);
    check("cal_start_delay", cs_cyc - first_fs, 1);
    check("no_timeout", to_cnt - to0, 0);
    check("busy_after", busy, 0);
    check("slot_valid", slot_valid, exp_valid);
    s = exp_q.pop_front();
    check("done_slot_valid", slot_valid[s], 1);
    check_slots();
  endtask

  initial begin
    int cs0, dn0, to0, waited;
    reset_n = 1'b0; cal_req = 1'b0; cal_slot = '0; cal_abort = 1'b0; clear_all = 1'b0;
    frame_start = 1'b0; Y_in = '0; U_in = '0; V_in = '0; rd_slot = '0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_cal_start", cal_start, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_slot_valid", slot_valid, 0);
    check_slots();
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    // Basic calibration of slot 1
    run_cal(1, 120, -20, 35, 1'b0);
    rd_slot = 2'd1; #1;
    check("basic_valid", slot_valid, 4'b0010);
    check("basic_y", rd_Y, 120);
    check("basic_umin", rd_U_min, -36);
    check("basic_umax", rd_U_max, -4);
    check("basic_vmin", rd_V_min, 19);
    check("basic_vmax", rd_V_max, 51);

    // Saturation of the window bounds
    run_cal(2, 200, -250, 250, 1'b0);
    rd_slot = 2'd2; #1;
    check("sat_umin", rd_U_min, -256);
    check("sat_umax", rd_U_max, -234);
    check("sat_vmin", rd_V_min, 234);
    check("sat_vmax", rd_V_max, 255);

    // Random calibrations, including overwrites of valid slots
    for (int k = 0; k < 6; k++)
      run_cal($urandom_range(0, NUM_SLOTS - 1), $urandom_range(0, 255),
              int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256, 1'b0);

    // Abort during ACCUM; a request issued while busy is dropped
    @(posedge clk); #1;
    cs0 = cs_cnt; dn0 = dn_cnt;
    Y_in = 8'd77; U_in = 9'sd5; V_in = 9'sd6;
    request(3, 1'b0);
    frame_pulse(10);
    repeat (5) @(posedge clk); #1;
    request(0, 1'b0);
    repeat (5) @(posedge clk); #1;
    cal_abort = 1'b1;
    @(negedge clk);
    check("abort_busy_before", busy, 1);
    @(posedge clk); #1;
    cal_abort = 1'b0;
    @(negedge clk);
    check("abort_busy_after", busy, 0);
    frame_pulse(10);
    frame_pulse(10);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("abort_no_done", dn_cnt - dn0, 0);
    check("abort_cal_start", cs_cnt - cs0, 1);
    check("abort_idle", busy, 0);
    check("abort_valid", slot_valid, exp_valid);
    check_slots();

    // Watchdog expiry in ARM
    @(posedge clk); #1;
    dn0 = dn_cnt; to0 = to_cnt;
    request(0, 1'b0);
    waited = 0;
    while (to_cnt == to0 && waited < 200) begin @(posedge clk); waited++; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("wd_pulses", to_cnt - to0, 1);
    check("wd_delay", to_cyc - (req_cyc + 1), WD_LIMIT);
    check("wd_idle", busy, 0);
    check("wd_no_done", dn_cnt - dn0, 0);
    check("wd_valid", slot_valid, exp_valid);
    check_slots();

    // clear_all while busy is ignored
    @(posedge clk); #1;
    request(0, 1'b0);
    repeat (5) @(posedge clk); #1;
    clear_all = 1'b1;
    @(posedge clk); #1;
    clear_all = 1'b0;
    repeat (3) @(posedge clk); #1;
    cal_abort = 1'b1;
    @(posedge clk); #1;
    cal_abort = 1'b0;
    @(negedge clk);
    check("clr_busy_idle", busy, 0);
    check("clr_busy_valid", slot_valid, exp_valid);

    // clear_all in IDLE clears valid bits, keeps data
    @(posedge clk); #1;
    clear_all = 1'b1;
    @(posedge clk); #1;
    clear_all = 1'b0;
    @(negedge clk);
    exp_valid = '0;
    check("clr_idle_valid", slot_valid, 0);
    check_slots();

    // Same-cycle cal_req and clear_all: calibration wins, valid bits kept
    run_cal(0, 10, 100, -100, 1'b0);
    run_cal(2, 30, -5, 7, 1'b1);
    check("clr_same_cycle_valid", slot_valid, 4'b0101);

    // Reset mid-calibration cuts off an in-flight cal_start
    @(posedge clk); #1;
    request(1, 1'b0);
    frame_pulse(8);
    check("live_cal_start", cal_start, 1);
    reset_n = 1'b0;
    #1;
    model_reset();
    check("async_cal_start", cal_start, 0);
    check("async_busy", busy, 0);
    check("async_done", done, 0);
    check("async_timeout", timeout, 0);
    check("async_valid", slot_valid, 0);
    check_slots();
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    run_cal(3, 55, 0, -1, 1'b0);
    check("post_reset_valid", slot_valid, 4'b1000);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/calib_sequencer.md
Name: calib_sequencer

Overview:
- Controller for the colour calibration datapath (RGB window accumulator plus YUV converter).
- Arms the calibration unit on a frame boundary and lets it accumulate for a fixed number of frames.
- Captures the resulting Y/U/V into one of several colour slots and derives per-slot U/V threshold windows.
- Sits between the user-input logic and the colour-tracking classifier, which reads the slots.

Parameters:
- NUM_SLOTS, 4, number of colour slots (max 2^SLOT_W).
- SLOT_W, 2, slot index width.
- NUM_FRAMES, 2, frames accumulated per calibration (>=1).
- TOL, 16, half-width of the U/V window in chroma units (0..255).
- TO_W, 24, width of the frame-watchdog counter; timeout occurs when the counter saturates at all ones.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cal_req  in  1  one-cycle request to calibrate slot cal_slot
- cal_slot  in  SLOT_W  target slot, sampled with cal_req
- cal_abort  in  1  abandon the current calibration
- clear_all  in  1  invalidate all slots (honoured only in IDLE)
- frame_start  in  1  one-cycle pulse at the start of each frame
- Y_in  in  8  Y from the calibration unit
- U_in  in  9 signed  U from the calibration unit
- V_in  in  9 signed  V from the calibration unit
- cal_start  out  1  one-cycle start pulse to the calibration unit
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after a slot is written
- timeout  out  1  one-cycle pulse on watchdog expiry
- slot_valid  out  NUM_SLOTS  per-slot valid bits
- rd_slot  in  SLOT_W  read-port select
- rd_Y  out  8  Y of the selected slot
- rd_U_min, rd_U_max, rd_V_min, rd_V_max  out  9 signed each  window bounds of the selected slot

Behaviour:
- Reset (asynchronous): state IDLE; all outputs 0; slot_valid 0; all slot registers 0; frame count and watchdog 0.
- IDLE:
  - cal_req=1 → latch cal_slot, go to ARM.
  - cal_req with cal_slot>=NUM_SLOTS is ignored.
  - clear_all=1 with no cal_req → slot_valid cleared next edge. If both are asserted, cal_req wins and clear_all is dropped.
- ARM:
  - Waits for frame_start.
  - On frame_start: cal_start=1 on the next cycle only, frame count=0, go to ACCUM.
- ACCUM:
  - Each frame_start increments the frame count.
  - When the count reaches NUM_FRAMES, go to LATCH.
  - A frame_start in the same cycle ARM→ACCUM is taken is not possible, since frame_start is a single pulse.
- LATCH (one cycle):
  - Write Y_in into the slot's Y register.
  - Write U_in−TOL / U_in+TOL and V_in−TOL / V_in+TOL into the bound registers.
  - Bound arithmetic is performed in 10-bit signed and saturated to −256..+255.
  - Set slot_valid[slot]; go to DONE.
- DONE: done=1 for one cycle, then IDLE. Throughput is one calibration per (NUM_FRAMES+1) frames.
- Ignored inputs: cal_req while busy is dropped (not queued); clear_all while busy is dropped.
- cal_abort in ARM/ACCUM/LATCH:
  - Return to IDLE next edge.
  - No slot write, no done; slot_valid and data unchanged.
  - cal_abort has priority over a simultaneous LATCH transition.
- Watchdog:
  - Counts cycles in ARM/ACCUM and resets on every frame_start.
  - At saturation: timeout pulse for one cycle, go to IDLE, no write.
- Recalibrating a valid slot overwrites it; that slot_valid stays 1 throughout.
- Read port is combinational from the slot registers. rd_slot>=NUM_SLOTS returns all zeros.
- Reset asserted mid-operation returns to the reset state immediately; a cal_start pulse in flight is cut off.

Test Plan:
- Basic calibration: reset, cal_req with slot=1, frame_start pulses every 100 cycles, Y/U/V=120/−20/+35 held → one cal_start one cycle after the 1st frame_start; LATCH after the 3rd; done pulse; slot_valid=0010; rd_slot=1 gives Y=120, U window −36..−4, V window 19..51.
- Saturation: U_in=−250, V_in=+250, TOL=16 → U_min=−256, U_max=−234, V_min=234, V_max=255.
- Abort and ignore: abort during ACCUM after the 1st frame → busy falls next edge, no done, slot_valid unchanged; a cal_req issued during ACCUM is never serviced.
- Watchdog: TO_W=6, no frame_start after cal_req → timeout pulse 63 cycles after entering ARM, then IDLE with slot_valid unchanged.
- Clear semantics: clear_all while busy → ignored; clear_all in IDLE → slot_valid=0; same-cycle cal_req and clear_all → calibration proceeds and valid bits are kept.
- Reset: assert reset_n low in ACCUM → all outputs 0 asynchronously; after release, a fresh calibration completes normally.
